// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU/branch encodings,
// FSM states and the registered control word. S_HALT exists only with CU_ILLEGAL_TRAP_EN.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h08;
  localparam logic [7:0] OP_SRL   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_ROR   = 8'h0B;
  localparam logic [7:0] OP_MULT  = 8'h0C;
  localparam logic [7:0] OP_BNE   = 8'h0D;
  localparam logic [7:0] OP_LWD   = 8'h0E;
  localparam logic [7:0] OP_SWD   = 8'h0F;
  localparam logic [7:0] OP_LWI   = 8'h10;
  localparam logic [7:0] OP_SWI   = 8'h11;

  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b100;
  localparam logic [2:0] ALU_SRA   = 3'b101;
  localparam logic [2:0] ALU_ROR   = 3'b110;
  localparam logic [2:0] ALU_MUL   = 3'b111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef CU_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic       mux1;
    logic       mux2;
    logic [2:0] aluop;
    logic [1:0] branch;
    logic       jump;
    logic       mem_rd;
    logic       mem_wr;
    logic       mult;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode to control-word decode; the FSM registers the result in DECODE.
// Unknown opcodes decode to an all-zero word with the illegal bit set.
module opcode_decoder
  import cpu_pkg::*;
#(
  parameter int O = 8
) (
  input  logic [O-1:0] i_opcode,
  output ctrl_word_t   o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_opcode)
      O'(OP_LOADI): o_cw.aluop = ALU_PASS;
      O'(OP_MOV):   o_cw.mux1  = 1'b1;
      O'(OP_ADD):   begin o_cw.mux1 = 1'b1; o_cw.aluop = ALU_ADD; end
      O'(OP_SUB):   begin o_cw.mux1 = 1'b1; o_cw.mux2 = 1'b1; o_cw.aluop = ALU_ADD; end
      O'(OP_AND):   begin o_cw.mux1 = 1'b1; o_cw.aluop = ALU_AND; end
      O'(OP_OR):    begin o_cw.mux1 = 1'b1; o_cw.aluop = ALU_OR; end
      O'(OP_J):     o_cw.jump = 1'b1;
      O'(OP_BEQ): begin
        o_cw.mux1   = 1'b1;
        o_cw.mux2   = 1'b1;
        o_cw.aluop  = ALU_ADD;
        o_cw.branch = BR_EQ;
      end
      O'(OP_SLL):   o_cw.aluop = ALU_SHIFT;
      O'(OP_SRL):   begin o_cw.mux2 = 1'b1; o_cw.aluop = ALU_SHIFT; end
      O'(OP_SRA):   begin o_cw.mux2 = 1'b1; o_cw.aluop = ALU_SRA; end
      O'(OP_ROR):   begin o_cw.mux2 = 1'b1; o_cw.aluop = ALU_ROR; end
      O'(OP_MULT):  begin o_cw.mux1 = 1'b1; o_cw.aluop = ALU_MUL; o_cw.mult = 1'b1; end
      O'(OP_BNE): begin
        o_cw.mux1   = 1'b1;
        o_cw.mux2   = 1'b1;
        o_cw.aluop  = ALU_ADD;
        o_cw.branch = BR_NE;
      end
      O'(OP_LWD):   begin o_cw.mux1 = 1'b1; o_cw.mem_rd = 1'b1; end
      O'(OP_SWD):   begin o_cw.mux1 = 1'b1; o_cw.mem_wr = 1'b1; end
      O'(OP_LWI):   o_cw.mem_rd = 1'b1;
      O'(OP_SWI):   o_cw.mem_wr = 1'b1;
      default:      o_cw.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with mult iteration and BUSYWAIT stalls.
// Define CU_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they retire as NOPs.
//
// state    | meaning
// S_FETCH  | IR_WRITE, latch opcode
// S_DECODE | register control word, clear mult counter
// S_EXEC   | drive ALU/branch controls; j/beq/bne retire here
// S_MEM    | data access, held while BUSYWAIT; stores retire here
// S_WB     | register write-back and PC update
// S_HALT   | illegal opcode trap, held until reset
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int I          = 32,
  parameter int O          = 8,
  parameter int Ao         = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [I-1:0]  i_instruction,
  input  logic          i_busywait,
  input  logic          i_zero,
  output logic          o_ir_write,
  output logic          o_pc_en,
  output logic          o_pc_sel,
  output logic          o_write,
  output logic          o_mux1,
  output logic          o_mux2,
  output logic          o_jump,
  output logic          o_write_mem,
  output logic          o_read_mem,
  output logic          o_reg_write,
  output logic [1:0]    o_branch,
  output logic [Ao-1:0] o_aluop,
  output logic          o_illegal
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [O-1:0] r_opcode;
  ctrl_word_t r_cw;
  ctrl_word_t w_dec_cw;
  logic [3:0] r_mul_cnt;
  logic       w_unused_ir;

  // Only the opcode field of the instruction matters to control.
  assign w_unused_ir = &{1'b0, i_instruction[I-O-1:0]};

  opcode_decoder #(.O(O)) u_dec (
    .i_opcode (r_opcode),
    .o_cw     (w_dec_cw)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_cw      <= '0;
      r_mul_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH) r_opcode <= i_instruction[I-1:I-O];
      if (r_state == S_DECODE) begin
        r_cw      <= w_dec_cw;
        r_mul_cnt <= '0;
      end else if (r_state == S_EXEC && r_cw.mult && r_mul_cnt != MUL_LAST) begin
        r_mul_cnt <= r_mul_cnt + 4'd1;
      end
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_dec_cw.illegal) r_illegal <= 1'b1;
  end

  assign o_illegal = r_illegal & ~i_reset;
`else
  assign o_illegal = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    o_ir_write   = 1'b0;
    o_pc_en      = 1'b0;
    o_pc_sel     = 1'b0;
    o_write      = 1'b0;
    o_mux1       = 1'b0;
    o_mux2       = 1'b0;
    o_jump       = 1'b0;
    o_write_mem  = 1'b0;
    o_read_mem   = 1'b0;
    o_reg_write  = 1'b0;
    o_branch     = BR_NONE;
    o_aluop      = '0;

    case (r_state)
      S_FETCH: begin
        o_ir_write   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
`ifdef CU_ILLEGAL_TRAP_EN
        if (w_dec_cw.illegal) w_next_state = S_HALT;
`endif
      end
      S_EXEC: begin
        o_mux1   = r_cw.mux1;
        o_mux2   = r_cw.mux2;
        o_aluop  = Ao'(r_cw.aluop);
        o_branch = r_cw.branch;
        o_jump   = r_cw.jump;
        if (r_cw.jump) begin
          o_pc_en      = 1'b1;
          o_pc_sel     = 1'b1;
          w_next_state = S_FETCH;
        end else if (r_cw.branch != BR_NONE) begin
          o_pc_en      = 1'b1;
          o_pc_sel     = (r_cw.branch == BR_EQ) ? i_zero : ~i_zero;
          w_next_state = S_FETCH;
        end else if (r_cw.mem_rd || r_cw.mem_wr) begin
          w_next_state = S_MEM;
        end else if (!r_cw.mult || r_mul_cnt == MUL_LAST) begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        o_mux1      = r_cw.mux1;
        o_mux2      = r_cw.mux2;
        o_aluop     = Ao'(r_cw.aluop);
        o_read_mem  = r_cw.mem_rd;
        o_write_mem = r_cw.mem_wr;
        o_reg_write = 1'b1;
        if (!i_busywait) begin
          if (r_cw.mem_wr) begin
            o_pc_en      = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end
      end
      S_WB: begin
        o_mux1       = r_cw.mux1;
        o_mux2       = r_cw.mux2;
        o_aluop      = Ao'(r_cw.aluop);
        o_write      = ~r_cw.illegal;
        o_pc_en      = 1'b1;
        w_next_state = S_FETCH;
      end
`ifdef CU_ILLEGAL_TRAP_EN
      S_HALT: w_next_state = S_HALT;
`endif
      default: w_next_state = S_FETCH;
    endcase

    // Reset silences every output in the same cycle, abandoning any memory access.
    if (i_reset) begin
      o_ir_write  = 1'b0;
      o_pc_en     = 1'b0;
      o_pc_sel    = 1'b0;
      o_write     = 1'b0;
      o_mux1      = 1'b0;
      o_mux2      = 1'b0;
      o_jump      = 1'b0;
      o_write_mem = 1'b0;
      o_read_mem  = 1'b0;
      o_reg_write = 1'b0;
      o_branch    = BR_NONE;
      o_aluop     = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed table, reset/trap sequences,
// and randomized instruction streams against a per-instruction timeline model.
module tb_multicycle_control_unit;

  localparam int MULC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_busywait, i_zero;
  logic [31:0] i_instruction;
  logic        o_ir_write, o_pc_en, o_pc_sel, o_write, o_mux1, o_mux2, o_jump;
  logic        o_write_mem, o_read_mem, o_reg_write, o_illegal;
  logic [1:0]  o_branch;
  logic [2:0]  o_aluop;

  multicycle_control_unit #(.I(32), .O(8), .Ao(3), .MUL_CYCLES(MULC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_instruction(i_instruction),
    .i_busywait(i_busywait), .i_zero(i_zero),
    .o_ir_write(o_ir_write), .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_write(o_write),
    .o_mux1(o_mux1), .o_mux2(o_mux2), .o_jump(o_jump), .o_write_mem(o_write_mem),
    .o_read_mem(o_read_mem), .o_reg_write(o_reg_write), .o_branch(o_branch),
    .o_aluop(o_aluop), .o_illegal(o_illegal)
  );

  typedef struct packed {
    logic ir_write, pc_en, pc_sel, write, mux1, mux2, jump, write_mem, read_mem, reg_write;
    logic [1:0] branch;
    logic [2:0] aluop;
    logic illegal;
  } outs_t;

  outs_t act;
  assign act = {o_ir_write, o_pc_en, o_pc_sel, o_write, o_mux1, o_mux2, o_jump,
                o_write_mem, o_read_mem, o_reg_write, o_branch, o_aluop, o_illegal};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Directed vectors: opcode, ZERO, BUSYWAIT cycles -> cycles to retire, EXEC levels, PC_SEL, writes.
  typedef struct {
    logic [7:0] op;
    logic       zero;
    int         nbusy;
    int         cycles;
    logic [2:0] aluop;
    logic       mux1;
    logic       mux2;
    logic       pc_sel;
    int         writes;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input vec_t v);
    int c = 0;
    int mem = 0;
    int wr = 0;
    logic done = 1'b0;
    logic [2:0] alu = '0;
    logic m1 = 1'b0, m2 = 1'b0, ps = 1'b0;
    string nm = $sformatf("op%02h", v.op);
    while (!done && c < 30) begin
      @(negedge clk);
      c++;
      i_zero = v.zero;
      i_busywait = 1'b0;
      i_instruction = (c == 1) ? {v.op, 24'($urandom)} : $urandom;
      #1;
      if (o_read_mem || o_write_mem) begin
        i_busywait = (mem < v.nbusy);
        mem++;
      end
      #1;
      if (c == 3) begin alu = o_aluop; m1 = o_mux1; m2 = o_mux2; end
      if (o_write) wr++;
      if (o_pc_en) begin done = 1'b1; ps = o_pc_sel; end
    end
    check({nm, " cycles"}, c, v.cycles);
    check({nm, " aluop"}, alu, v.aluop);
    check({nm, " mux1"}, m1, v.mux1);
    check({nm, " mux2"}, m2, v.mux2);
    check({nm, " pc_sel"}, ps, v.pc_sel);
    check({nm, " writes"}, wr, v.writes);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  // Reference timeline: the per-cycle inputs and expected outputs of one instruction.
  typedef struct packed {
    logic  zero;
    logic  busy;
    outs_t exp;
  } cyc_t;

  cyc_t q[$];

  function automatic outs_t levels(input logic [7:0] op);
    outs_t o = '0;
    o.mux1 = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    o.mux2 = op inside {8'h03, 8'h07, 8'h0D, 8'h09, 8'h0A, 8'h0B};
    if (op inside {8'h02, 8'h03, 8'h07, 8'h0D}) o.aluop = 3'd1;
    else if (op == 8'h04) o.aluop = 3'd2;
    else if (op == 8'h05) o.aluop = 3'd3;
    else if (op inside {8'h08, 8'h09}) o.aluop = 3'd4;
    else if (op == 8'h0A) o.aluop = 3'd5;
    else if (op == 8'h0B) o.aluop = 3'd6;
    else if (op == 8'h0C) o.aluop = 3'd7;
    return o;
  endfunction

  function automatic void build(input logic [7:0] op, input int nb);
    cyc_t c;
    bit is_load  = op inside {8'h0E, 8'h10};
    bit is_store = op inside {8'h0F, 8'h11};
    bit is_flow  = op inside {8'h06, 8'h07, 8'h0D};
    int nexec    = (op == 8'h0C) ? MULC : 1;
    q.delete();
    c.zero = 1'($urandom); c.busy = 1'($urandom); c.exp = '0; c.exp.ir_write = 1'b1;
    q.push_back(c);
    c.zero = 1'($urandom); c.busy = 1'($urandom); c.exp = '0;
    q.push_back(c);
    for (int i = 0; i < nexec; i++) begin
      c.zero = 1'($urandom); c.busy = 1'($urandom); c.exp = levels(op);
      if (op == 8'h06) begin c.exp.jump = 1'b1; c.exp.pc_en = 1'b1; c.exp.pc_sel = 1'b1; end
      if (op == 8'h07) begin c.exp.branch = 2'b01; c.exp.pc_en = 1'b1; c.exp.pc_sel = c.zero; end
      if (op == 8'h0D) begin c.exp.branch = 2'b10; c.exp.pc_en = 1'b1; c.exp.pc_sel = !c.zero; end
      q.push_back(c);
    end
    if (is_load || is_store) begin
      for (int i = 0; i <= nb; i++) begin
        c.zero = 1'($urandom); c.busy = (i < nb); c.exp = levels(op);
        c.exp.read_mem = is_load; c.exp.write_mem = is_store; c.exp.reg_write = 1'b1;
        if (i == nb && is_store) c.exp.pc_en = 1'b1;
        q.push_back(c);
      end
    end
    if (!is_flow && !is_store) begin
      c.zero = 1'($urandom); c.busy = 1'($urandom); c.exp = levels(op);
      c.exp.write = 1'b1; c.exp.pc_en = 1'b1;
      q.push_back(c);
    end
  endfunction

  logic [7:0] r_op;
  int         r_nb;
  int         cnt;
  outs_t      halt_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_busywait = 1'b1; i_zero = 1'b1; i_instruction = {8'h02, 24'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 check("reset outputs", act, 0);
    @(posedge clk);
    #1 i_reset = 1'b0; i_busywait = 1'b0;
    #1 check("first ir_write", o_ir_write, 1);

    tbl.push_back(vec_t'{8'h02, 1'b0, 0, 4, 3'b001, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h07, 1'b1, 0, 3, 3'b001, 1'b1, 1'b1, 1'b1, 0});
    tbl.push_back(vec_t'{8'h07, 1'b0, 0, 3, 3'b001, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back(vec_t'{8'h0D, 1'b0, 0, 3, 3'b001, 1'b1, 1'b1, 1'b1, 0});
    tbl.push_back(vec_t'{8'h06, 1'b0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back(vec_t'{8'h0C, 1'b0, 0, 3 + MULC, 3'b111, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h0E, 1'b0, 3, 8, 3'b000, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h0F, 1'b1, 2, 6, 3'b000, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back(vec_t'{8'h10, 1'b0, 0, 5, 3'b000, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h11, 1'b0, 0, 4, 3'b000, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back(vec_t'{8'h0A, 1'b0, 0, 4, 3'b101, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back(vec_t'{8'h05, 1'b1, 0, 4, 3'b011, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h08, 1'b0, 0, 4, 3'b100, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back(vec_t'{8'h09, 1'b0, 0, 4, 3'b100, 1'b0, 1'b1, 1'b0, 1});
`ifndef CU_ILLEGAL_TRAP_EN
    tbl.push_back(vec_t'{8'h20, 1'b0, 0, 4, 3'b000, 1'b0, 1'b0, 1'b0, 0});
`endif
    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset in the middle of a stalled swi access.
    @(negedge clk); i_instruction = {8'h11, 24'h0}; i_busywait = 1'b1;
    @(negedge clk); i_instruction = $urandom;
    @(negedge clk);
    @(negedge clk); #2 check("swi mem write_mem", o_write_mem, 1);
    @(negedge clk); i_reset = 1'b1;
    #2 check("swi reset outputs", act, 0);
    @(posedge clk);
    #1 i_reset = 1'b0; i_instruction = {8'h02, 24'h0};
    #1 check("ir_write after reset", o_ir_write, 1);
    check("write_mem after reset", o_write_mem, 0);
    i_busywait = 1'b0;
    do_reset();

`ifdef CU_ILLEGAL_TRAP_EN
    halt_exp = '0;
    halt_exp.illegal = 1'b1;
    @(negedge clk); i_instruction = {8'h20, 24'h0}; i_busywait = 1'b0;
    #2 check("illegal fetch", o_ir_write, 1);
    @(negedge clk); #2 check("illegal in decode", o_illegal, 0);
    @(negedge clk); #2 check("halt outputs", act, halt_exp);
    cnt = 0;
    repeat (6) begin
      @(negedge clk); i_instruction = $urandom;
      #2 cnt += int'(o_ir_write);
    end
    check("halt no ir_write", cnt, 0);
    check("halt illegal sticky", o_illegal, 1);
    do_reset();
    #1 check("illegal cleared", o_illegal, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      r_op = 8'($urandom_range(0, 17));
      r_nb = $urandom_range(0, 3);
      build(r_op, r_nb);
      for (int k = 0; k < q.size(); k++) begin
        @(negedge clk);
        i_zero = q[k].zero;
        i_busywait = q[k].busy;
        i_instruction = (k == 0) ? {r_op, 24'($urandom)} : $urandom;
        #2 check($sformatf("rand op%02h cyc%0d", r_op, k), act, q[k].exp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
